// File: rtl/div_4_seq.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake.
// Results are registered one cycle after the DONE state is entered.
module div_4_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int         CW     = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] d_r;
  logic [CW-1:0]    count;
  logic             dz_r;
  logic             accept;

  // One restoring step: shift {R,Q} left, trial-subtract D, keep or restore.
  // R never exceeds 2^(WIDTH-1)-1 before its final shift, so no bit is lost.
  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] r,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH-1:0] rs;
    logic [WIDTH:0]   trial;
    rs    = {r[WIDTH-2:0], q[WIDTH-1]};
    trial = {1'b0, rs} - {1'b0, d};
    if (!trial[WIDTH]) div_step = {trial[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
    else               div_step = {rs, q[WIDTH-2:0], 1'b0};
  endfunction

  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      q_r         <= '0;
      r_r         <= '0;
      d_r         <= '0;
      count       <= '0;
      dz_r        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: ;
        S_CALC: begin
          {r_r, q_r} <= div_step(r_r, q_r, d_r);
          count      <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state <= S_DONE;
            busy  <= 1'b0;
          end
        end
        S_DONE: begin
          done        <= 1'b1;
          quotient    <= dz_r ? '1  : q_r;
          remainder   <= dz_r ? q_r : r_r;
          div_by_zero <= dz_r;
          state       <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
      // A start in DONE overrides the return to IDLE (back-to-back operation).
      if (accept) begin
        d_r   <= divisor;
        q_r   <= dividend;
        r_r   <= '0;
        count <= '0;
        dz_r  <= (divisor == '0);
        state <= (divisor == '0) ? S_DONE : S_CALC;
        busy  <= (divisor != '0);
      end
    end
  end

endmodule

// File: tb/tb_div_4_seq.sv
// Directed bench for div_4_seq: per-scenario tasks with inline checks.
module tb_div_4_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int errors;
  int checks;

  div_4_seq #(.WIDTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one operation; start is sampled at the following rising edge (E0).
  task automatic issue_start(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // lat = index k of edge E_k after which done is seen (-1 on timeout).
  task automatic wait_done(output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (quotient !== 4'd0) begin errors++; $display("FAIL reset_q: got %0d want 0", quotient); end
    checks++; if (remainder !== 4'd0) begin errors++; $display("FAIL reset_r: got %0d want 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b want 0", div_by_zero); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bcnt;
    issue_start(4'd13, 4'd4);
    wait_done(lat, bcnt);
    checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency: got %0d want 5", lat); end
    checks++; if (bcnt !== 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 4", bcnt); end
    checks++; if (quotient !== 4'd3) begin errors++; $display("FAIL basic_q: got %0d want 3", quotient); end
    checks++; if (remainder !== 4'd1) begin errors++; $display("FAIL basic_r: got %0d want 1", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dz: got %b want 0", div_by_zero); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    checks++; if (quotient !== 4'd3) begin errors++; $display("FAIL basic_q_hold: got %0d want 3", quotient); end
  endtask

  task automatic test_edges();
    logic [3:0] va [4] = '{4'd15, 4'd3, 4'd0, 4'd15};
    logic [3:0] vb [4] = '{4'd1,  4'd7, 4'd5, 4'd15};
    logic [3:0] vq [4] = '{4'd15, 4'd0, 4'd0, 4'd1};
    logic [3:0] vr [4] = '{4'd0,  4'd3, 4'd0, 4'd0};
    int lat, bcnt;
    for (int i = 0; i < 4; i++) begin
      issue_start(va[i], vb[i]);
      wait_done(lat, bcnt);
      checks++; if (lat !== 5) begin errors++; $display("FAIL edge%0d_latency: got %0d want 5", i, lat); end
      checks++; if (quotient !== vq[i]) begin errors++; $display("FAIL edge%0d_q: got %0d want %0d", i, quotient, vq[i]); end
      checks++; if (remainder !== vr[i]) begin errors++; $display("FAIL edge%0d_r: got %0d want %0d", i, remainder, vr[i]); end
    end
  endtask

  task automatic test_div_zero();
    int lat, bcnt;
    issue_start(4'd9, 4'd0);
    wait_done(lat, bcnt);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency: got %0d want 1", lat); end
    checks++; if (bcnt !== 0) begin errors++; $display("FAIL dz_busy: got %0d want 0", bcnt); end
    checks++; if (quotient !== 4'd15) begin errors++; $display("FAIL dz_q: got %0d want 15", quotient); end
    checks++; if (remainder !== 4'd9) begin errors++; $display("FAIL dz_r: got %0d want 9", remainder); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", div_by_zero); end
    issue_start(4'd8, 4'd2);
    wait_done(lat, bcnt);
    checks++; if (lat !== 5) begin errors++; $display("FAIL dz_next_latency: got %0d want 5", lat); end
    checks++; if (quotient !== 4'd4) begin errors++; $display("FAIL dz_next_q: got %0d want 4", quotient); end
    checks++; if (remainder !== 4'd0) begin errors++; $display("FAIL dz_next_r: got %0d want 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_next_flag: got %b want 0", div_by_zero); end
  endtask

  task automatic test_start_while_busy();
    int ndone = 0;
    int lat = -1;
    logic [3:0] q = 4'd0;
    logic [3:0] r = 4'd0;
    issue_start(4'd12, 4'd5);
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin start = 1'b1; dividend = 4'd7; divisor = 4'd2; end
      if (k == 2) start = 1'b0;
      if (done) begin
        ndone++;
        if (lat < 0) begin lat = k; q = quotient; r = remainder; end
      end
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_ignore_dones: got %0d want 1", ndone); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL busy_ignore_latency: got %0d want 5", lat); end
    checks++; if (q !== 4'd2) begin errors++; $display("FAIL busy_ignore_q: got %0d want 2", q); end
    checks++; if (r !== 4'd2) begin errors++; $display("FAIL busy_ignore_r: got %0d want 2", r); end
  endtask

  task automatic test_back_to_back();
    int t1 = -1;
    int t2 = -1;
    logic [3:0] q1 = 4'd0, r1 = 4'd0, q2 = 4'd0, r2 = 4'd0;
    @(negedge clk);
    start = 1'b1; dividend = 4'd10; divisor = 4'd3;
    @(posedge clk);
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      if (k == 4) begin dividend = 4'd11; divisor = 4'd4; end
      if (done) begin
        if (t1 < 0) begin t1 = k; q1 = quotient; r1 = remainder; end
        else if (t2 < 0) begin t2 = k; q2 = quotient; r2 = remainder; end
      end
      if (k == 5) start = 1'b0;
    end
    checks++; if (t1 !== 5) begin errors++; $display("FAIL b2b_first_latency: got %0d want 5", t1); end
    checks++; if (q1 !== 4'd3 || r1 !== 4'd1) begin errors++; $display("FAIL b2b_first: got q=%0d r=%0d want q=3 r=1", q1, r1); end
    checks++; if (t2 - t1 !== 5) begin errors++; $display("FAIL b2b_gap: got %0d want 5", t2 - t1); end
    checks++; if (q2 !== 4'd2 || r2 !== 4'd3) begin errors++; $display("FAIL b2b_second: got q=%0d r=%0d want q=2 r=3", q2, r2); end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt;
    int ndone = 0;
    issue_start(4'd14, 4'd3);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    checks++; if (quotient !== 4'd0 || remainder !== 4'd0) begin errors++; $display("FAIL rmid_result: got q=%0d r=%0d want 0 0", quotient, remainder); end
    checks++; if (done !== 1'b0 || div_by_zero !== 1'b0) begin errors++; $display("FAIL rmid_flags: got done=%b dz=%b want 0 0", done, div_by_zero); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL rmid_no_done: got %0d want 0", ndone); end
    issue_start(4'd14, 4'd3);
    wait_done(lat, bcnt);
    checks++; if (lat !== 5) begin errors++; $display("FAIL rmid_after_latency: got %0d want 5", lat); end
    checks++; if (quotient !== 4'd4 || remainder !== 4'd2) begin errors++; $display("FAIL rmid_after: got q=%0d r=%0d want q=4 r=2", quotient, remainder); end
  endtask

  task automatic test_exhaustive();
    int lat, bcnt;
    int eq, er, el;
    logic edz;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin eq = 15; er = a; edz = 1'b1; el = 1; end
        else begin eq = a / b; er = a % b; edz = 1'b0; el = 5; end
        issue_start(4'(a), 4'(b));
        wait_done(lat, bcnt);
        checks++; if (lat !== el) begin errors++; $display("FAIL exh_latency %0d/%0d: got %0d want %0d", a, b, lat, el); end
        checks++; if (quotient !== 4'(eq)) begin errors++; $display("FAIL exh_q %0d/%0d: got %0d want %0d", a, b, quotient, eq); end
        checks++; if (remainder !== 4'(er)) begin errors++; $display("FAIL exh_r %0d/%0d: got %0d want %0d", a, b, remainder, er); end
        checks++; if (div_by_zero !== edz) begin errors++; $display("FAIL exh_dz %0d/%0d: got %b want %b", a, b, div_by_zero, edz); end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
